// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and geometry for the multi-cycle external SRAM controller.
package sram_mem_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLo   = 2'd1,
      StHi   = 2'd2,
      StDone = 2'd3
   } state_e;

   localparam int unsigned WAIT_CYCLES_DEF = 5;
   localparam int unsigned BASE_ADDR_DEF   = 1024;
   localparam int unsigned SRAM_AW_DEF     = 18;
   localparam int unsigned SRAM_DW_DEF     = 16;

endpackage

// File: rtl/sram_mem_ctrl.sv
// Splits each 32-bit CPU load/store into two 16-bit asynchronous SRAM accesses,
// holding ready low until both halves are done.
module sram_mem_ctrl
   import sram_mem_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
   parameter int unsigned SRAM_AW     = SRAM_AW_DEF,
   parameter int unsigned SRAM_DW     = SRAM_DW_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_mem_r_en,
   input  logic               i_mem_w_en,
   input  logic [31:0]        i_addr,
   input  logic [31:0]        i_wdata,
   output logic [31:0]        o_rdata,
   output logic               o_ready,
   output logic [SRAM_AW-1:0] o_sram_addr,
   output logic [SRAM_DW-1:0] o_sram_dq,
   input  logic [SRAM_DW-1:0] i_sram_dq,
   output logic               o_sram_dq_oe,
   output logic               o_sram_we_n,
   output logic               o_sram_ce_n,
   output logic               o_sram_oe_n,
   output logic               o_sram_ub_n,
   output logic               o_sram_lb_n
);

   localparam int unsigned CW = $clog2(WAIT_CYCLES) + 1;
   localparam int unsigned WW = SRAM_AW - 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

   state_e              r_state;
   logic [CW-1:0]       r_cnt;
   logic                r_is_wr;
   logic [WW-1:0]       r_word;
   logic [31:0]         r_wdata;
   logic [31:0]         r_rdata;
   logic [SRAM_AW-1:0]  r_sram_addr;
   logic [SRAM_DW-1:0]  r_sram_dq;
   logic                r_sram_dq_oe;
   logic                r_sram_we_n;

   logic                w_req;
   logic [WW-1:0]       w_word;
   logic [CW-1:0]       w_cnt_inc;
   logic                w_last;
   logic                w_next_last;

   assign w_req       = i_mem_r_en | i_mem_w_en;
   // addr[1:0] drop out of the shift; wrap modulo the SRAM size comes from the truncation
   assign w_word      = WW'((i_addr - 32'(BASE_ADDR)) >> 2);
   assign w_cnt_inc   = r_cnt + CW'(1);
   assign w_last      = (r_cnt == CNT_LAST);
   assign w_next_last = (w_cnt_inc == CNT_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_cnt        <= '0;
         r_is_wr      <= 1'b0;
         r_word       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_sram_addr  <= '0;
         r_sram_dq    <= '0;
         r_sram_dq_oe <= 1'b0;
         r_sram_we_n  <= 1'b1;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_req) begin
                  r_state      <= StLo;
                  r_cnt        <= '0;
                  r_is_wr      <= i_mem_w_en;
                  r_word       <= w_word;
                  r_wdata      <= i_wdata;
                  r_sram_addr  <= {w_word, 1'b0};
                  r_sram_dq    <= i_wdata[SRAM_DW-1:0];
                  r_sram_dq_oe <= i_mem_w_en;
                  r_sram_we_n  <= ~i_mem_w_en;
               end
            end
            StLo: begin
               if (w_last) begin
                  r_state     <= StHi;
                  r_cnt       <= '0;
                  r_sram_addr <= {r_word, 1'b1};
                  r_sram_dq   <= r_wdata[2*SRAM_DW-1:SRAM_DW];
                  r_sram_we_n <= ~r_is_wr;
                  if (!r_is_wr) begin
                     r_rdata[SRAM_DW-1:0] <= i_sram_dq;
                  end
               end else begin
                  r_cnt       <= w_cnt_inc;
                  // release we_n one cycle early so address/data hold past the write pulse
                  r_sram_we_n <= ~r_is_wr | w_next_last;
               end
            end
            StHi: begin
               if (w_last) begin
                  r_state      <= StDone;
                  r_cnt        <= '0;
                  r_sram_dq_oe <= 1'b0;
                  r_sram_we_n  <= 1'b1;
                  if (!r_is_wr) begin
                     r_rdata[2*SRAM_DW-1:SRAM_DW] <= i_sram_dq;
                  end
               end else begin
                  r_cnt       <= w_cnt_inc;
                  r_sram_we_n <= ~r_is_wr | w_next_last;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign o_ready      = ~w_req | (r_state == StDone);
   assign o_rdata      = r_rdata;
   assign o_sram_addr  = r_sram_addr;
   assign o_sram_dq    = r_sram_dq;
   assign o_sram_dq_oe = r_sram_dq_oe;
   assign o_sram_we_n  = r_sram_we_n;
   assign o_sram_ce_n  = 1'b0;
   assign o_sram_oe_n  = 1'b0;
   assign o_sram_ub_n  = 1'b0;
   assign o_sram_lb_n  = 1'b0;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: behavioural async SRAM, directed table, reset-abort case
// and randomized accesses checked against a word-level memory model.
module tb_sram_mem_ctrl;
   import sram_mem_ctrl_pkg::*;

   localparam int unsigned WC   = 5;
   localparam int unsigned AW   = SRAM_AW_DEF;
   localparam int unsigned BASE = BASE_ADDR_DEF;

   logic          clk = 1'b0;
   logic          rst;
   logic          r_en;
   logic          w_en;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_o;
   logic [15:0]   sram_dq_i;
   logic          sram_dq_oe;
   logic          sram_we_n;
   logic          ce_n, oe_n, ub_n, lb_n;

   sram_mem_ctrl #(
      .WAIT_CYCLES (WC),
      .BASE_ADDR   (BASE),
      .SRAM_AW     (AW),
      .SRAM_DW     (16)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_mem_r_en   (r_en),
      .i_mem_w_en   (w_en),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .o_rdata      (rdata),
      .o_ready      (ready),
      .o_sram_addr  (sram_addr),
      .o_sram_dq    (sram_dq_o),
      .i_sram_dq    (sram_dq_i),
      .o_sram_dq_oe (sram_dq_oe),
      .o_sram_we_n  (sram_we_n),
      .o_sram_ce_n  (ce_n),
      .o_sram_oe_n  (oe_n),
      .o_sram_ub_n  (ub_n),
      .o_sram_lb_n  (lb_n)
   );

   always #5 clk = ~clk;

   // Async SRAM: a write lands on the rising edge of we_n, provided the address held.
   logic [15:0]   sram [0:(1<<AW)-1];
   logic          prev_we_n = 1'b1;
   logic [AW-1:0] prev_addr = '0;
   logic [15:0]   prev_dq   = '0;

   assign sram_dq_i = sram[sram_addr];

   always @(negedge clk) begin
      if (sram_dq_oe && !prev_we_n && sram_we_n && sram_addr == prev_addr)
         sram[prev_addr] = prev_dq;
      prev_we_n = sram_we_n;
      prev_addr = sram_addr;
      prev_dq   = sram_dq_o;
   end

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: whole 32-bit words indexed by SRAM word number.
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] ref_rdata = '0;

   function automatic int unsigned word_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (off >> 2) % (1 << (AW - 1));
   endfunction

   function automatic logic [31:0] ref_read(input int unsigned wd);
      if (ref_mem.exists(wd)) return ref_mem[wd];
      return 32'h0;
   endfunction

   // Issues one access at the next edge, leaves inputs asserted after the DONE cycle.
   task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output logic [AW-1:0] first_addr);
      int low = 0;
      int wel = 0;
      int bad = 0;
      int unsigned wd;
      logic [AW-1:0] seen [$];
      @(posedge clk);
      #1;
      r_en = r; w_en = w; addr = a; wdata = d;
      wd = word_of(a);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready) break;
         low++;
         if (!sram_we_n) wel++;
         if (low >= 2) seen.push_back(sram_addr);
      end
      check("latency", 32'(low), 32'(2 * WC + 1));
      check("we_low_cycles", 32'(wel), w ? 32'(2 * (WC - 1)) : 32'd0);
      foreach (seen[i]) begin
         if (seen[i] != AW'(2 * wd + ((i < WC) ? 0 : 1))) bad++;
      end
      check("addr_seq", 32'(bad), 32'd0);
      first_addr = (seen.size() > 0) ? seen[0] : '1;
      if (w) ref_mem[wd] = d;
      else   ref_rdata = ref_read(wd);
      check("rdata", rdata, ref_rdata);
      if (w) begin
         check("sram_lo", 32'(sram[AW'(2 * wd)]), 32'(d[15:0]));
         check("sram_hi", 32'(sram[AW'(2 * wd + 1)]), 32'(d[31:16]));
      end
   endtask

   task automatic go_idle(input int cycles);
      @(posedge clk);
      #1;
      r_en = 1'b0; w_en = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check("idle_ready_we_oe", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'b110);
      end
   endtask

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic        idle_before;
      logic [31:0] exp_rdata;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs [5];

   initial begin
      logic [AW-1:0] fa;
      for (int i = 0; i < (1 << AW); i++) sram[i] = 16'h0;

      vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 32'h0,        32'd0};
      vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b1, 32'hDEADBEEF, 32'd0};
      vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h12345678, 1'b1, 32'hDEADBEEF, 32'd2};
      vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        1'b0, 32'h12345678, 32'd2};
      vecs[4] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1'b1, 32'h12345678, 32'd4};

      rst = 1'b1; r_en = 1'b0; w_en = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_rdata", rdata, 32'h0);
      check("rst_sram_addr", 32'(sram_addr), 32'h0);
      check("rst_dq_o", 32'(sram_dq_o), 32'h0);
      check("rst_ready_we_oe", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'b110);
      check("tied_low", {28'd0, ce_n, oe_n, ub_n, lb_n}, 32'h0);

      go_idle(20);

      foreach (vecs[k]) begin
         if (vecs[k].idle_before) go_idle(1);
         do_access(vecs[k].r, vecs[k].w, vecs[k].a, vecs[k].d, fa);
         check("vec_rdata", rdata, vecs[k].exp_rdata);
         check("vec_first_addr", 32'(fa), vecs[k].exp_lo);
      end

      // Reset in the second HI cycle of a store: high half must not reach the SRAM.
      go_idle(2);
      @(posedge clk);
      #1;
      r_en = 1'b0; w_en = 1'b1; addr = 32'd1040; wdata = 32'hAAAA5555;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1; w_en = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_ready_we_oe", {29'd0, ready, sram_we_n, sram_dq_oe}, 32'b110);
      check("abort_rdata", rdata, 32'h0);
      check("abort_sram_addr", 32'(sram_addr), 32'h0);
      check("abort_sram_lo", 32'(sram[8]), 32'h5555);
      check("abort_sram_hi", 32'(sram[9]), 32'h0);
      ref_rdata = 32'h0;
      ref_mem[4] = 32'h00005555;

      for (int n = 0; n < 60; n++) begin
         int unsigned op;
         logic [31:0] a;
         op = $urandom_range(0, 3);
         if ($urandom_range(0, 3) != 0)
            a = BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
         else
            a = $urandom;
         case (op)
            0: go_idle($urandom_range(1, 3));
            1: do_access(1'b1, 1'b0, a, $urandom, fa);
            2: do_access(1'b0, 1'b1, a, $urandom, fa);
            default: do_access(1'b1, 1'b1, a, $urandom, fa);
         endcase
      end
      go_idle(2);

      foreach (ref_mem[wd]) begin
         check("final_lo", 32'(sram[AW'(2 * wd)]), 32'(ref_mem[wd][15:0]));
         check("final_hi", 32'(sram[AW'(2 * wd + 1)]), 32'(ref_mem[wd][31:16]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
